// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: word-organised SRAM target for the CPU data memory channel
// with programmable request-accept and read-response latencies.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-low reset
//   Address             byte address, bits [ADDR_WIDTH+1:2] select the word
//   MemWrite, MemRead   requests, held by the initiator until Mem_Req_Ack
//   Write_data/strb     lane-replicated write data and byte enables
//   Mem_Req_Ack         one-cycle request-accepted pulse
//   Read_data(_Valid)   read response, held until Read_data_Ack
//   Read_data_Ack       initiator ready for the response
//   busy                high whenever the FSM is not idle
module cpu_mem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int ACK_DELAY  = 2,
  parameter int RESP_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  input  logic        MemRead,
  output logic        Mem_Req_Ack,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ack,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, REQ_WAIT, ACK, RESP_WAIT, RESP} state_t;
  localparam logic [7:0] AD1 = 8'(ACK_DELAY - 1);
  localparam logic [7:0] RD1 = 8'(RESP_DELAY - 1);
  state_t state;
  logic [7:0] cnt;
  logic [31:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic req;
  logic unused_addr;
  assign idx = Address[ADDR_WIDTH+1:2];
  assign req = MemRead | MemWrite;
  assign unused_addr = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};
  // Outputs decode the state register only, so they never follow inputs combinationally.
  assign Mem_Req_Ack = state == ACK;
  assign Read_data_Valid = state == RESP;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      Read_data <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          state <= (ACK_DELAY == 0) ? ACK : REQ_WAIT;
          cnt <= AD1;
        end
        REQ_WAIT: if (!req) state <= IDLE;
          else if (cnt == '0) state <= ACK;
          else cnt <= cnt - 8'd1;
        // A write (including the read+write violation) ends here; only a pure read responds.
        ACK: if (MemRead && !MemWrite) begin
          Read_data <= mem[idx];
          state <= (RESP_DELAY == 0) ? RESP : RESP_WAIT;
          cnt <= RD1;
        end else state <= IDLE;
        RESP_WAIT: if (cnt == '0) state <= RESP;
          else cnt <= cnt - 8'd1;
        RESP: if (Read_data_Ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // The array has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (rst && state == ACK && MemWrite)
      for (int i = 0; i < 4; i++)
        if (Write_strb[i]) mem[idx][8*i +: 8] <= Write_data[8*i +: 8];
  end
`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst && state == ACK && MemRead && MemWrite)
      $warning("cpu_mem_responder: MemRead and MemWrite both high; write done, no response");
  end
`endif
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: table-driven and scoreboard bench for cpu_mem_responder.
module tb_cpu_mem_responder;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  logic [31:0] Address = '0, Write_data = '0;
  logic [3:0] Write_strb = '0;
  logic MemRead = 0, MemWrite = 0, Read_data_Ack = 0;
  int sel = 0;
  logic ack_v [3];
  logic val_v [3];
  logic busy_v [3];
  logic [31:0] rd_v [3];
  int n_chk = 0, n_fail = 0;
  logic [31:0] q [$];

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : u
      cpu_mem_responder #(
        .ADDR_WIDTH(12),
        .ACK_DELAY(g == 0 ? 2 : g == 1 ? 0 : 3),
        .RESP_DELAY(g == 1 ? 0 : 1)
      ) dut (
        .clk(clk), .rst(rst), .Address(Address),
        .MemWrite(MemWrite && sel == g), .Write_data(Write_data), .Write_strb(Write_strb),
        .MemRead(MemRead && sel == g), .Mem_Req_Ack(ack_v[g]), .Read_data(rd_v[g]),
        .Read_data_Valid(val_v[g]), .Read_data_Ack(Read_data_Ack), .busy(busy_v[g])
      );
    end
  endgenerate

  typedef struct {
    logic we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0] strb;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [12];

  function automatic int ad_of(int s);
    return s == 0 ? 2 : s == 1 ? 0 : 3;
  endfunction
  function automatic int rd_of(int s);
    return s == 1 ? 0 : 1;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst && val_v[sel] && Read_data_Ack) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: got response %h want none", rd_v[sel]);
      end else check("rd_data", rd_v[sel], q.pop_front());
    end
  end

  task automatic xact(input vec_t v);
    int k = 0;
    Address = v.addr;
    Write_data = v.data;
    Write_strb = v.strb;
    MemWrite = v.we;
    MemRead = !v.we;
    Read_data_Ack = 1;
    if (!v.we) q.push_back(v.exp);
    do begin
      step();
      k++;
    end while (!ack_v[sel] && k < 50);
    check("ack_lat", k, 1 + ad_of(sel));
    step();
    k++;
    MemRead = 0;
    MemWrite = 0;
    check("ack_pulse", ack_v[sel], 0);
    if (!v.we) begin
      while (!val_v[sel] && k < 50) begin
        step();
        k++;
      end
      check("rd_lat", k, 2 + ad_of(sel) + rd_of(sel));
      step();
    end
    check("busy_after", busy_v[sel], 0);
  endtask

  initial begin
    int k;
    logic acc;
    tbl[0]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'b1111, 32'h0};
    tbl[1]  = '{1'b0, 32'h0000_0040, 32'h0,         4'b0000, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 32'h0000_0080, 32'h1122_3344, 4'b1111, 32'h0};
    tbl[3]  = '{1'b1, 32'h0000_0080, 32'hAAAA_AAAA, 4'b0100, 32'h0};
    tbl[4]  = '{1'b0, 32'h0000_0080, 32'h0,         4'b0000, 32'h11AA_3344};
    tbl[5]  = '{1'b1, 32'h0000_0080, 32'hFFFF_FFFF, 4'b0000, 32'h0};
    tbl[6]  = '{1'b0, 32'h0000_0080, 32'h0,         4'b0000, 32'h11AA_3344};
    tbl[7]  = '{1'b1, 32'h0000_4004, 32'h5A5A_5A5A, 4'b1111, 32'h0};
    tbl[8]  = '{1'b0, 32'h0000_0004, 32'h0,         4'b0000, 32'h5A5A_5A5A};
    tbl[9]  = '{1'b1, 32'h0000_0083, 32'h0000_0055, 4'b0001, 32'h0};
    tbl[10] = '{1'b0, 32'h0000_4080, 32'h0,         4'b0000, 32'h11AA_3355};
    tbl[11] = '{1'b0, 32'h0000_0042, 32'h0,         4'b0000, 32'hDEAD_BEEF};
    step();
    step();
    for (int s = 0; s < 3; s++) begin
      check("rst_ack", ack_v[s], 0);
      check("rst_valid", val_v[s], 0);
      check("rst_data", rd_v[s], 0);
      check("rst_busy", busy_v[s], 0);
    end
    rst = 1;
    step();
    sel = 0;
    for (int i = 0; i < 12; i++) xact(tbl[i]);

    sel = 1;
    xact('{1'b1, 32'h10, 32'hCAFE_F00D, 4'b1111, 32'h0});
    Address = 32'h10;
    MemRead = 1;
    Read_data_Ack = 0;
    q.push_back(32'hCAFE_F00D);
    step();
    check("ack0_lat", ack_v[1], 1);
    step();
    MemRead = 0;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", val_v[1], 1);
      check("hold_data", rd_v[1], 32'hCAFE_F00D);
      step();
    end
    Read_data_Ack = 1;
    check("hold_valid6", val_v[1], 1);
    check("hold_data6", rd_v[1], 32'hCAFE_F00D);
    step();
    check("drop_valid", val_v[1], 0);
    check("drop_busy", busy_v[1], 0);
    check("keep_data", rd_v[1], 32'hCAFE_F00D);

    sel = 2;
    xact('{1'b1, 32'h20, 32'h0102_0304, 4'b1111, 32'h0});
    Address = 32'h20;
    Write_data = 32'hFFFF_FFFF;
    Write_strb = 4'b1111;
    MemWrite = 1;
    step();
    check("wd_busy", busy_v[2], 1);
    MemWrite = 0;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      acc = acc | ack_v[2] | val_v[2];
    end
    check("wd_noack", acc, 0);
    check("wd_idle", busy_v[2], 0);
    MemRead = 1;
    step();
    MemRead = 0;
    acc = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      acc = acc | ack_v[2] | val_v[2];
    end
    check("rdw_noack", acc, 0);
    check("rdw_idle", busy_v[2], 0);
    xact('{1'b0, 32'h20, 32'h0, 4'b0000, 32'h0102_0304});

    sel = 0;
    Address = 32'h40;
    MemRead = 1;
    Read_data_Ack = 0;
    q.push_back(32'hDEAD_BEEF);
    k = 0;
    while (!val_v[0] && k < 50) begin
      step();
      k++;
      if (k == 4) MemRead = 0;
    end
    check("pre_rst_lat", k, 5);
    rst = 0;
    step();
    rst = 1;
    q.delete();
    check("mid_rst_ack", ack_v[0], 0);
    check("mid_rst_valid", val_v[0], 0);
    check("mid_rst_data", rd_v[0], 0);
    check("mid_rst_busy", busy_v[0], 0);
    step();
    step();
    check("post_rst_valid", val_v[0], 0);
    xact('{1'b0, 32'h40, 32'h0, 4'b0000, 32'hDEAD_BEEF});
    sel = 1;
    xact('{1'b0, 32'h10, 32'h0, 4'b0000, 32'hCAFE_F00D});
    check("sb_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
